aes_round_enc: RTL and testbench

Iterative AES-128 encryption core: the forward (cipher) counterpart of the inverse-round decryption datapath. It accepts one 128-bit plaintext and cipher key on a start strobe, executes the initial AddRoundKey plus ten rounds, with one transform per clock and on-the-fly key expansion, and returns the ciphertext with a one-cycle done pulse. It sits beside the decryption core so the pair can run round-trip, and can optionally export the final round key that the decryption core consumes.

---
 rtl/aes_round_enc_if.sv | 19 +
 rtl/aes_round_enc.sv | 180 ++++++++++++++++++
 tb/tb_aes_round_enc.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/aes_round_enc_if.sv
// Request/result bundle for the iterative AES-128 encryption core.
// LASTKEY exists only when AES_ENC_LASTKEY_EN is defined.
interface aes_round_enc_if;
    logic         start;
    logic [127:0] IN;
    logic [127:0] KEY;
    logic         busy;
    logic         done;
    logic [127:0] ENC;
`ifdef AES_ENC_LASTKEY_EN
    logic [127:0] LASTKEY;

    modport master (output start, IN, KEY, input busy, done, ENC, LASTKEY);
    modport slave  (input start, IN, KEY, output busy, done, ENC, LASTKEY);
`else
    modport master (output start, IN, KEY, input busy, done, ENC);
    modport slave  (input start, IN, KEY, output busy, done, ENC);
`endif
endinterface

// File: rtl/aes_round_enc.sv
// Iterative AES-128 encryption core: initial AddRoundKey plus ten rounds, one transform per clock,
// key expanded on the fly. Define AES_ENC_LASTKEY_EN to export the round-10 key on LASTKEY.
module aes_round_enc (
    input  logic           clk,
    input  logic           reset,
    aes_round_enc_if.slave bus
);
    typedef enum logic [2:0] {
        IDLE = 3'b000,
        INIT = 3'b001,
        ADD  = 3'b010,
        SUB  = 3'b011,
        SHI  = 3'b100,
        MIX  = 3'b101,
        FIN  = 3'b111
    } state_t;

    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    // Indexed directly by rnd (1..10); unused slots are zero.
    localparam logic [7:0] RCON [16] = '{
        8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40,
        8'h80, 8'h1b, 8'h36, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00
    };

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [31:0] mix_col(input logic [31:0] col);
        logic [7:0] a0, a1, a2, a3;
        a0 = col[31:24];
        a1 = col[23:16];
        a2 = col[15:8];
        a3 = col[7:0];
        return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
    endfunction

    state_t       state_q, state_d;
    logic [3:0]   rnd_q, rnd_d;
    logic [127:0] st_q, st_d;
    logic [127:0] rk_q, rk_d;
    logic [127:0] enc_q, enc_d;
    logic [127:0] sub_st, shift_st, mix_st, next_rk;
    logic [31:0]  key_tmp;
`ifdef AES_ENC_LASTKEY_EN
    logic [127:0] lastkey_q, lastkey_d;
`endif

    // Round transforms all act on the current state; byte i lives at bits [127-8i -: 8].
    always_comb begin
        sub_st   = '0;
        shift_st = '0;
        mix_st   = '0;
        for (int i = 0; i < 16; i++) begin
            sub_st[127-8*i -: 8] = SBOX[st_q[127-8*i -: 8]];
        end
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                shift_st[127-8*(r+4*c) -: 8] = st_q[127-8*(r+4*((c+r)%4)) -: 8];
            end
        end
        for (int c = 0; c < 4; c++) begin
            mix_st[127-32*c -: 32] = mix_col(st_q[127-32*c -: 32]);
        end
    end

    // Key schedule step: SubWord(RotWord(w3)) ^ Rcon folds forward through the four words.
    always_comb begin
        key_tmp = {SBOX[rk_q[23:16]], SBOX[rk_q[15:8]], SBOX[rk_q[7:0]], SBOX[rk_q[31:24]]}
                  ^ {RCON[rnd_q], 24'h000000};
        next_rk[127:96] = rk_q[127:96] ^ key_tmp;
        next_rk[95:64]  = rk_q[95:64]  ^ next_rk[127:96];
        next_rk[63:32]  = rk_q[63:32]  ^ next_rk[95:64];
        next_rk[31:0]   = rk_q[31:0]   ^ next_rk[63:32];
    end

    always_comb begin
        state_d = state_q;
        rnd_d   = rnd_q;
        st_d    = st_q;
        rk_d    = rk_q;
        enc_d   = enc_q;
`ifdef AES_ENC_LASTKEY_EN
        lastkey_d = lastkey_q;
`endif
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    st_d    = bus.IN;
                    rk_d    = bus.KEY;
                    rnd_d   = 4'd1;
                    state_d = INIT;
                end
            end
            INIT: begin
                st_d    = st_q ^ rk_q;
                state_d = SUB;
            end
            SUB: begin
                st_d    = sub_st;
                rk_d    = next_rk;
                state_d = SHI;
            end
            SHI: begin
                st_d    = shift_st;
                state_d = (rnd_q == 4'd10) ? ADD : MIX;
            end
            MIX: begin
                st_d    = mix_st;
                state_d = ADD;
            end
            ADD: begin
                st_d = st_q ^ rk_q;
                if (rnd_q == 4'd10) begin
                    enc_d   = st_q ^ rk_q;
`ifdef AES_ENC_LASTKEY_EN
                    lastkey_d = rk_q;
`endif
                    state_d = FIN;
                end else begin
                    rnd_d   = rnd_q + 4'd1;
                    state_d = SUB;
                end
            end
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            rnd_q   <= '0;
            st_q    <= '0;
            rk_q    <= '0;
            enc_q   <= '0;
`ifdef AES_ENC_LASTKEY_EN
            lastkey_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            rnd_q   <= rnd_d;
            st_q    <= st_d;
            rk_q    <= rk_d;
            enc_q   <= enc_d;
`ifdef AES_ENC_LASTKEY_EN
            lastkey_q <= lastkey_d;
`endif
        end
    end

    assign bus.busy = (state_q != IDLE);
    assign bus.done = (state_q == FIN);
    assign bus.ENC  = enc_q;
`ifdef AES_ENC_LASTKEY_EN
    assign bus.LASTKEY = lastkey_q;
`endif

endmodule

// File: tb/tb_aes_round_enc.sv
// Scoreboard bench for aes_round_enc: known-answer vectors, ignored start pulses, back-to-back
// accept spacing, input changes after accept and mid-run reset abort.
module tb_aes_round_enc;
    logic clk;
    logic reset;
    int   cycle;
    int   n_compared;
    int   n_mismatched;

    aes_round_enc_if bus ();

    aes_round_enc dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic [127:0] enc;
        logic [127:0] lk;
        int           acc;
    } exp_t;

    exp_t sb_q[$];

    localparam logic [127:0] C1_IN  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] C1_ENC = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] C1_LK  = 128'h13111d7fe3944a17f307a78b4d2b30c5;
    localparam logic [127:0] B_IN   = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] B_ENC  = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] B_LK   = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] Z_ENC  = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;
    localparam logic [127:0] Z_LK   = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cycle = 0;
    always @(posedge clk) cycle <= cycle + 1;

    task automatic checkOutput(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_compared++;
        if (got !== exp) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic waitEdges(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Drives one request; the edge it returns after is the accepting edge.
    task automatic applyStimulus(input logic [127:0] in_v, input logic [127:0] key_v,
                                 input logic [127:0] exp_enc, input logic [127:0] exp_lk);
        exp_t e;
        bus.IN    = in_v;
        bus.KEY   = key_v;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        e.enc = exp_enc;
        e.lk  = exp_lk;
        e.acc = cycle;
        sb_q.push_back(e);
    endtask

    task automatic waitDrain(input int budget);
        int n;
        n = 0;
        while ((sb_q.size() != 0 || bus.busy) && n < budget) begin
            waitEdges(1);
            n++;
        end
        checkOutput("drain_pending", 128'(sb_q.size()), 128'd0);
        checkOutput("drain_busy", {127'b0, bus.busy}, 128'd0);
    endtask

    // Completion monitor: every done pops one expectation, so extra or doubled pulses show up.
    always @(negedge clk) begin
        if (reset && bus.done) begin
            if (sb_q.size() == 0) begin
                checkOutput("spurious_done", {127'b0, bus.done}, 128'd0);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                checkOutput("enc", bus.ENC, e.enc);
                checkOutput("latency", 128'(cycle - e.acc), 128'd40);
`ifdef AES_ENC_LASTKEY_EN
                checkOutput("lastkey", bus.LASTKEY, e.lk);
`endif
            end
        end
    end

    initial begin
        int first_acc;
        n_compared   = 0;
        n_mismatched = 0;
        reset     = 1'b1;
        bus.start = 1'b0;
        bus.IN    = '0;
        bus.KEY   = '0;
        #3 reset = 1'b0;
        waitEdges(3);
        checkOutput("rst_busy", {127'b0, bus.busy}, 128'd0);
        checkOutput("rst_done", {127'b0, bus.done}, 128'd0);
        checkOutput("rst_enc", bus.ENC, 128'd0);
`ifdef AES_ENC_LASTKEY_EN
        checkOutput("rst_lastkey", bus.LASTKEY, 128'd0);
`endif

        // C.1 launched in the same cycle reset releases, inputs scrambled right after accept.
        reset = 1'b1;
        applyStimulus(C1_IN, C1_KEY, C1_ENC, C1_LK);
        first_acc = cycle;
        bus.IN  = {$urandom, $urandom, $urandom, $urandom};
        bus.KEY = {$urandom, $urandom, $urandom, $urandom};
        checkOutput("busy_after_accept", {127'b0, bus.busy}, 128'd1);
        waitEdges(4);
        bus.start = 1'b1;
        waitEdges(1);
        bus.start = 1'b0;
        checkOutput("busy_ignores_start", {127'b0, bus.busy}, 128'd1);
        waitEdges(35);
        checkOutput("done_at_40", {127'b0, bus.done}, 128'd1);
        bus.IN    = B_IN;
        bus.KEY   = B_KEY;
        bus.start = 1'b1;
        waitEdges(1);
        checkOutput("fin_ignores_start", {127'b0, bus.busy}, 128'd0);
        applyStimulus(B_IN, B_KEY, B_ENC, B_LK);
        checkOutput("accept_gap", 128'(cycle - first_acc), 128'd42);
        checkOutput("busy_second", {127'b0, bus.busy}, 128'd1);
        waitDrain(100);
        checkOutput("enc_hold", bus.ENC, B_ENC);

        applyStimulus(128'd0, 128'd0, Z_ENC, Z_LK);
        waitDrain(100);

        // Reset mid-run: outputs clear at once and the aborted block never completes.
        applyStimulus(C1_IN, C1_KEY, C1_ENC, C1_LK);
        waitEdges(19);
        reset = 1'b0;
        #1;
        checkOutput("abort_busy", {127'b0, bus.busy}, 128'd0);
        checkOutput("abort_done", {127'b0, bus.done}, 128'd0);
        checkOutput("abort_enc", bus.ENC, 128'd0);
        sb_q.delete();
        waitEdges(2);
        reset = 1'b1;
        waitEdges(50);
        checkOutput("post_reset_busy", {127'b0, bus.busy}, 128'd0);
        checkOutput("post_reset_enc", bus.ENC, 128'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end
endmodule
